// File: rtl/alu_pkg.sv
// Shared ALU control codes, requester ids and the legal-opcode check used by the
// arbiter and the ALU core.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic REQ_EX  = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   function automatic logic is_legal_alu_op(input logic [3:0] ctrl);
      case (ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Fixed-priority grant for the shared ALU: requester 0 wins unless requester 1
// has been denied for MAX_WAIT cycles, in which case requester 1 is forced through.
module alu_arb_grant
   import alu_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       req0_valid_i,
   input  logic       req1_valid_i,
   output logic [1:0] grant_o
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] wait_cnt_q;
   logic [3:0] wait_cnt_d;
   logic       force_aux;

   // Grant selection; nothing is granted while reset is held.
   always_comb begin
      force_aux = req1_valid_i && (wait_cnt_q == MAX_WAIT_C);
      grant_o   = 2'b00;
      if (reset_i) begin
         grant_o = 2'b00;
      end else if (force_aux) begin
         grant_o[REQ_AUX] = 1'b1;
      end else if (req0_valid_i) begin
         grant_o[REQ_EX] = 1'b1;
      end else if (req1_valid_i) begin
         grant_o[REQ_AUX] = 1'b1;
      end else begin
         grant_o = 2'b00;
      end
   end

   // Starvation counter: counts denied cycles of requester 1, saturating.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!req1_valid_i || grant_o[REQ_AUX]) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q < MAX_WAIT_C) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wait_cnt_q <= 4'd0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU: arbitrates, registers operands,
// drives the ALU and returns a registered, requester-tagged result (latency 2).
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [3:0]       req0_ctrl,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [3:0]       req1_ctrl,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic [1:0]       rsp_valid,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_err
);

   logic [1:0]       grant;

   logic             op_valid_q, op_valid_d;
   logic             op_id_q, op_id_d;
   logic [3:0]       op_ctrl_q, op_ctrl_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;

   logic [1:0]       rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_err_q, rsp_err_d;

   alu_arb_grant #(
      .MAX_WAIT (MAX_WAIT)
   ) u_grant (
      .clk_i        (clk),
      .reset_i      (reset),
      .req0_valid_i (req0_valid),
      .req1_valid_i (req1_valid),
      .grant_o      (grant)
   );

   assign req0_ready = grant[REQ_EX];
   assign req1_ready = grant[REQ_AUX];

   // Operand registers are zeroed when nothing transfers, so the ALU sees 0s when idle.
   assign alu_ctrl = op_ctrl_q;
   assign alu_a    = op_a_q;
   assign alu_b    = op_b_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_err   = rsp_err_q;

   // Stage A: select the granted payload for the operand registers.
   always_comb begin
      op_valid_d = 1'b0;
      op_id_d    = REQ_EX;
      op_ctrl_d  = 4'b0000;
      op_a_d     = '0;
      op_b_d     = '0;
      if (grant[REQ_EX]) begin
         op_valid_d = 1'b1;
         op_id_d    = REQ_EX;
         op_ctrl_d  = req0_ctrl;
         op_a_d     = req0_a;
         op_b_d     = req0_b;
      end else if (grant[REQ_AUX]) begin
         op_valid_d = 1'b1;
         op_id_d    = REQ_AUX;
         op_ctrl_d  = req1_ctrl;
         op_a_d     = req1_a;
         op_b_d     = req1_b;
      end else begin
         op_valid_d = 1'b0;
      end
   end

   // Stage B: capture the ALU result; unsupported codes report 0/zero with err.
   always_comb begin
      rsp_valid_d = 2'b00;
      rsp_data_d  = rsp_data_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_err_d   = rsp_err_q;
      if (op_valid_q) begin
         rsp_valid_d[op_id_q] = 1'b1;
         if (is_legal_alu_op(op_ctrl_q)) begin
            rsp_data_d = alu_out;
            rsp_zero_d = alu_zero;
            rsp_err_d  = 1'b0;
         end else begin
            rsp_data_d = '0;
            rsp_zero_d = 1'b1;
            rsp_err_d  = 1'b1;
         end
      end else begin
         rsp_valid_d = 2'b00;
      end
   end

   // Pipeline registers; reset discards anything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_valid_q  <= 1'b0;
         op_id_q     <= REQ_EX;
         op_ctrl_q   <= 4'b0000;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         op_valid_q  <= op_valid_d;
         op_id_q     <= op_id_d;
         op_ctrl_q   <= op_ctrl_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push hand-computed responses, a
// negedge monitor pops and compares them, including the expected arrival cycle.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        alu_zero;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_zero, rsp_err;

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        zero;
      logic        err;
      int          exp_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   alu_arbiter #(.WIDTH(32), .MAX_WAIT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ctrl  (req0_ctrl),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_ctrl  (req1_ctrl),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .alu_ctrl   (alu_ctrl),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU attached to the DUT's ALU port
   always_comb begin
      case (alu_ctrl)
         4'b0000: alu_out = alu_a & alu_b;
         4'b0001: alu_out = alu_a | alu_b;
         4'b0010: alu_out = alu_a + alu_b;
         4'b0110: alu_out = alu_a - alu_b;
         4'b0111: alu_out = {31'd0, (alu_a < alu_b)};
         4'b1100: alu_out = ~(alu_a | alu_b);
         default: alu_out = 32'd0;
      endcase
      alu_zero = (alu_out == 32'd0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (rsp_valid !== 2'b00) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=%b expected no response (cycle %0d)", rsp_valid, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_valid", {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
            check("rsp_data", rsp_data, e.data);
            check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            check("rsp_cycle", cyc, e.exp_cyc);
         end
      end else if (sb.size() > 0 && sb[0].exp_cyc < cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL missing_rsp: got none expected response at cycle %0d (cycle %0d)", sb[0].exp_cyc, cyc);
         void'(sb.pop_front());
      end
   end

   // Present one request (call at a negedge), hold until accepted, push expectation.
   task automatic send(input bit p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input bit z, input bit e, output int acc);
      int n;
      n   = 0;
      acc = -1;
      if (!p) begin
         req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b;
      end
      while (acc < 0 && n < 40) begin
         #1;
         check("ready_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
         if (p ? req1_ready : req0_ready) begin
            acc = cyc;
            sb.push_back('{p, d, z, e, cyc + 2});
         end
         @(negedge clk);
         n++;
      end
      if (acc < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got no ready expected ready for requester %0d", p);
      end
      if (!p) req0_valid = 1'b0;
      else    req1_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
      check({tag, "_rsp_data"}, rsp_data, 32'd0);
      check({tag, "_rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
      check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
      check({tag, "_alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
      check({tag, "_alu_a"}, alu_a, 32'd0);
      check({tag, "_alu_b"}, alu_b, 32'd0);
   endtask

   int acc, acc0, acc1, s;
   int a0[$];
   int a1[$];
   int exp0[9] = '{0, 1, 2, 3, 5, 6, 7, 8, 10};
   int exp1[2] = '{4, 9};

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req0_ctrl = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
      req1_valid = 1'b0; req1_ctrl = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      #1;
      check("idle_ready0", {31'd0, req0_ready}, 32'd0);
      check("idle_ready1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);

      // Single req0 ADD, accepted in the cycle it is presented
      s = cyc;
      send(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, acc);
      check("single_accept_cycle", acc, s);
      repeat (3) @(negedge clk);

      // Back-to-back SUB then SLT
      send(1'b0, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, acc);
      send(1'b0, ALU_SLT, 32'd3, 32'd8, 32'd1, 1'b0, 1'b0, acc);
      repeat (3) @(negedge clk);

      // Requester 1 alone: NOR 0,0
      send(1'b1, ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, acc);
      // Unsigned SLT with large a: 0xFFFFFFFF < 1 is false
      send(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, acc);
      // Unsupported control code
      send(1'b0, 4'b0011, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, acc);
      repeat (3) @(negedge clk);

      // Contention: both held valid, requester 1 forced every fifth cycle
      s = cyc;
      fork
         begin
            for (int i = 1; i <= 9; i++) begin
               send(1'b0, ALU_ADD, 32'(i), 32'(i), 32'(2 * i), 1'b0, 1'b0, acc0);
               a0.push_back(acc0 - s);
            end
         end
         begin
            for (int j = 0; j < 2; j++) begin
               send(1'b1, ALU_OR, 32'(j), 32'h10, 32'(j) | 32'h10, 1'b0, 1'b0, acc1);
               a1.push_back(acc1 - s);
            end
         end
      join
      for (int k = 0; k < 9; k++) check("grant_req0_cycle", (k < a0.size()) ? a0[k] : -1, exp0[k]);
      for (int k = 0; k < 2; k++) check("grant_req1_cycle", (k < a1.size()) ? a1[k] : -1, exp1[k]);
      repeat (4) @(negedge clk);

      // Reset the cycle after a transfer: in-flight request is dropped
      send(1'b0, ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, acc);
      reset = 1'b1;
      sb.delete();
      req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1;
      #1;
      check("reset_ready0", {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
      check_all_zero("post_reset");
      reset = 1'b0;
      req0_valid = 1'b0;
      repeat (4) @(negedge clk);
      s = cyc;
      send(1'b0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, acc);
      check("post_reset_accept", acc, s);
      repeat (4) @(negedge clk);

      check("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU datapath between two requesters:
  - requester 0: EX-stage operand path, the high-priority port.
  - requester 1: auxiliary unit, e.g. branch/address compare helper.
- Accepts at most one request per cycle through a valid/ready handshake, registers the operands, drives the ALU, and returns a registered result tagged to the originating requester.
- Fixed priority to requester 0, with a starvation counter that guarantees requester 1 forward progress.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- MAX_WAIT, 4, cycles requester 1 may be denied while valid before it is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ctrl  in  4  requester 0 ALU control code.
- req0_a  in  WIDTH  requester 0 operand rs.
- req0_b  in  WIDTH  requester 0 operand rt.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid, req1_ctrl, req1_a, req1_b, req1_ready  same as above, for requester 1.
- alu_ctrl  out  4  to ALU control input.
- alu_a  out  WIDTH  to ALU rs.
- alu_b  out  WIDTH  to ALU rt.
- alu_out  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  2  one-hot; bit i = response for requester i this cycle.
- rsp_data  out  WIDTH  registered ALU result.
- rsp_zero  out  1  registered zero flag.
- rsp_err  out  1  the request carried an unsupported control code.

Behaviour:
- Handshake:
  - A request transfers when reqN_valid && reqN_ready, sampled at the rising edge.
  - A requester holds valid and payload stable until ready.
  - reqN_ready is combinational from valids and arbitration state. It is never asserted without the matching valid, and at most one ready is high per cycle.
- Arbitration:
  - Default: requester 0 wins whenever req0_valid.
  - wait_cnt (4 bits) increments each cycle req1_valid && !req1_ready. It saturates at MAX_WAIT and clears when req1 transfers or req1_valid is low.
  - When wait_cnt == MAX_WAIT and req1_valid, requester 1 is granted and requester 0 is stalled that cycle.
- Pipeline, fixed latency 2, throughput 1/cycle, no response backpressure:
  - Stage A, at the transfer edge: capture ctrl, a, b, source id, and a valid bit into operand registers.
  - Stage B, next cycle: alu_ctrl/alu_a/alu_b are driven directly from the operand registers. At the end of that cycle, capture alu_out and alu_zero into rsp_data and rsp_zero, and set rsp_valid[id] for exactly one cycle.
  - The response for a request accepted at edge k appears during the cycle after edge k+1.
- Idle behaviour:
  - When the operand register is invalid, alu_ctrl=4'b0000 and alu_a=alu_b=0.
  - In that case rsp_valid=0 on the next cycle, and rsp_data/rsp_zero hold their last values.
- Legal codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned compare), 1100 NOR.
  - Any other code is still issued.
  - The response carries rsp_err=1 and rsp_data=0, matching the ALU default.
  - rsp_err is 0 for legal codes.
- Reset, synchronous:
  - All outputs and state go to 0: rsp_valid=2'b00, rsp_data=0, rsp_zero=0, rsp_err=0, alu_* = 0, wait_cnt=0, operand valid=0.
  - Ready outputs are forced 0 during the reset cycle.
  - Requests in flight when reset is asserted are discarded and produce no response.
- Simultaneous events:
  - Both valid with wait_cnt < MAX_WAIT: requester 0 granted, wait_cnt++.
  - Both valid with wait_cnt == MAX_WAIT: requester 1 granted, wait_cnt cleared.
  - New accept in the same cycle a response is emitted: both proceed; no bubble.

Decomposition:
- Shared package alu_pkg:
  - ALU control code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - An is_legal_alu_op function.
  - Requester id constants REQ_EX=0, REQ_AUX=1.
  - The ALU core reuses these constants.
- One natural sub-module: alu_arb_grant.
  - Contains the combinational priority logic plus the wait_cnt register.
  - Outputs the grant vector.
- The operand and response registers stay in the top module.

Test Plan:
- Single req0: ctrl=0010, a=5, b=7 -> req0_ready=1 same cycle; 2 cycles later rsp_valid=01, rsp_data=12, rsp_zero=0, rsp_err=0.
- Back-to-back req0 SUB 9-9 then SLT 3<8 -> responses on consecutive cycles: data=0/zero=1, then data=1/zero=0; no bubble.
- req0 and req1 held valid continuously, MAX_WAIT=4 -> req1_ready rises on the 5th cycle. Grant pattern is 0,0,0,0,1 repeating; wait_cnt returns to 0 after each req1 grant.
- req1 alone, NOR a=0, b=0 -> rsp_valid=10, rsp_data=32'hFFFFFFFF.
- Illegal ctrl=4'b0011 with a=1, b=1 -> rsp_data=0, rsp_zero=1, rsp_err=1.
- reset asserted the cycle after a transfer -> no rsp_valid afterwards; all outputs 0 the cycle after reset; first post-reset req0 ADD 1+1 returns 2 with latency 2.
